// File: rtl/core_task_server.sv
`default_nettype none
// ============================================================================
// Module     : core_task_server
// Description: CQ-side responder for one core's dequeue/start/finish protocol.
//              Ready-task FIFO with per-entry abort invalidation, running-task
//              tracking, abort pulse to the core and finish report to the CQ.
//              Optional counters: define CORE_TASK_SERVER_STATS_EN.
//              task_t layout: ttype occupies the low TTYPE_W bits of the task.
// Revision   : 1.0 - initial release
// ============================================================================
module core_task_server #(
    parameter int DEPTH   = 4,
    parameter int CORE_ID = 0,
    parameter int TASK_W  = 32,
    parameter int TTYPE_W = 4,
    parameter int SLOT_W  = 6,
    parameter int CHILD_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cq_push_valid,
    output logic               cq_push_ready,
    input  logic [TASK_W-1:0]  cq_push_task,
    input  logic [SLOT_W-1:0]  cq_push_slot,
    input  logic               task_arvalid,
    input  logic [TTYPE_W-1:0] task_araddr,
    output logic               task_rvalid,
    output logic [TASK_W-1:0]  task_rdata,
    output logic [SLOT_W-1:0]  task_rslot,
    input  logic               start_task_valid,
    output logic               start_task_ready,
    input  logic [SLOT_W-1:0]  start_task_slot,
    input  logic               finish_task_valid,
    output logic               finish_task_ready,
    input  logic [SLOT_W-1:0]  finish_task_slot,
    input  logic [CHILD_W-1:0] finish_task_num_children,
    input  logic               finish_task_undo_log_write,
    input  logic               abort_req_valid,
    input  logic [SLOT_W-1:0]  abort_req_slot,
    output logic               abort_running_task,
    output logic [SLOT_W-1:0]  abort_running_slot,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [SLOT_W-1:0]  done_slot,
    output logic [CHILD_W-1:0] done_num_children,
    output logic               done_undo_write,
    output logic               done_aborted,
    output logic [31:0]        stat_dispatched,
    output logic [31:0]        stat_finished,
    output logic [31:0]        stat_aborted
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DISPATCHED = 2'd1,
        ST_RUNNING    = 2'd2,
        ST_REPORT     = 2'd3
    } state_t;

    logic [TASK_W-1:0]  r_task [DEPTH];
    logic [SLOT_W-1:0]  r_slot [DEPTH];
    logic [DEPTH-1:0]   r_ent_vld;
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    state_t             r_state;
    logic [SLOT_W-1:0]  r_run_slot;
    logic               r_aborted;
    logic               r_abort_pulse;
    logic [SLOT_W-1:0]  r_abort_slot;
    logic               r_done_valid;
    logic [SLOT_W-1:0]  r_done_slot;
    logic [CHILD_W-1:0] r_done_children;
    logic               r_done_undo;
    logic               r_done_aborted;

    logic               w_empty, w_full, w_head_ok, w_skip, w_grant, w_pop, w_push;
    logic               w_start_hs, w_finish_hs, w_done_hs, w_abort_run, w_abort_grant;
    logic [TASK_W-1:0]  w_head_task;
    logic [SLOT_W-1:0]  w_head_slot;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_full_cnt);
    assign w_head_task = r_task[r_rd_ptr];
    assign w_head_slot = r_slot[r_rd_ptr];
    assign w_head_ok   = !w_empty && r_ent_vld[r_rd_ptr];
    // Aborted entries stay counted until they reach the head and drain here.
    assign w_skip      = !w_empty && !r_ent_vld[r_rd_ptr];
    assign w_grant     = task_arvalid && w_head_ok && (r_state == ST_IDLE)
                      && (w_head_task[TTYPE_W-1:0] == task_araddr);
    assign w_pop       = w_grant || w_skip;
    assign w_push      = cq_push_valid && !w_full;

    assign w_start_hs  = start_task_valid && (r_state == ST_DISPATCHED);
    assign w_finish_hs = finish_task_valid && finish_task_ready;
    assign w_done_hs   = r_done_valid && done_ready;
    assign w_abort_run = abort_req_valid && !r_aborted && (abort_req_slot == r_run_slot)
                      && ((r_state == ST_DISPATCHED) || (r_state == ST_RUNNING));
    assign w_abort_grant = abort_req_valid && w_grant && (abort_req_slot == w_head_slot);

    assign cq_push_ready      = !w_full;
    assign task_rvalid        = w_grant;
    assign task_rdata         = w_head_task;
    assign task_rslot         = w_head_slot;
    assign start_task_ready   = (r_state == ST_DISPATCHED);
    assign finish_task_ready  = (r_state == ST_RUNNING) && !r_done_valid;
    assign abort_running_task = r_abort_pulse;
    assign abort_running_slot = r_abort_slot;
    assign done_valid         = r_done_valid;
    assign done_slot          = r_done_slot;
    assign done_num_children  = r_done_children;
    assign done_undo_write    = r_done_undo;
    assign done_aborted       = r_done_aborted;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_task[r_wr_ptr] <= cq_push_task;
            r_slot[r_wr_ptr] <= cq_push_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent_vld <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (abort_req_valid && r_ent_vld[i] && (r_slot[i] == abort_req_slot))
                    r_ent_vld[i] <= 1'b0;
            end
            if (w_pop) begin
                r_ent_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_ent_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_run_slot      <= '0;
            r_aborted       <= 1'b0;
            r_abort_pulse   <= 1'b0;
            r_abort_slot    <= '0;
            r_done_valid    <= 1'b0;
            r_done_slot     <= '0;
            r_done_children <= '0;
            r_done_undo     <= 1'b0;
            r_done_aborted  <= 1'b0;
        end else begin
            r_abort_pulse <= w_abort_run || w_abort_grant;
            if (w_abort_run || w_abort_grant)
                r_abort_slot <= abort_req_slot;
            if (w_grant)
                r_aborted <= w_abort_grant;
            else if (w_abort_run)
                r_aborted <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_grant) begin
                    r_run_slot <= w_head_slot;
                    r_state    <= ST_DISPATCHED;
                end
                ST_DISPATCHED: if (w_start_hs) r_state <= ST_RUNNING;
                ST_RUNNING: if (w_finish_hs) begin
                    // An abort landing with the finish is still reported.
                    r_done_valid    <= 1'b1;
                    r_done_slot     <= r_run_slot;
                    r_done_children <= finish_task_num_children;
                    r_done_undo     <= finish_task_undo_log_write;
                    r_done_aborted  <= r_aborted || w_abort_run;
                    r_state         <= ST_REPORT;
                end
                ST_REPORT: if (w_done_hs) begin
                    r_done_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CORE_TASK_SERVER_STATS_EN
    logic [31:0] r_stat_disp, r_stat_fin, r_stat_abt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_disp <= '0;
            r_stat_fin  <= '0;
            r_stat_abt  <= '0;
        end else begin
            if (w_grant)                      r_stat_disp <= r_stat_disp + 1'b1;
            if (w_done_hs)                    r_stat_fin  <= r_stat_fin + 1'b1;
            if (w_abort_run || w_abort_grant) r_stat_abt  <= r_stat_abt + 1'b1;
        end
    end
    assign stat_dispatched = r_stat_disp;
    assign stat_finished   = r_stat_fin;
    assign stat_aborted    = r_stat_abt;
`else
    assign stat_dispatched = '0;
    assign stat_finished   = '0;
    assign stat_aborted    = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_start_hs)
            assert (start_task_slot == r_run_slot)
            else $error("core %0d: start slot %0d differs from running slot %0d",
                        CORE_ID, start_task_slot, r_run_slot);
        if (!rst && w_finish_hs)
            assert (finish_task_slot == r_run_slot)
            else $error("core %0d: finish slot %0d differs from running slot %0d",
                        CORE_ID, finish_task_slot, r_run_slot);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_task_server.sv
`default_nettype none
// ============================================================================
// Module     : tb_core_task_server
// Description: Randomized scoreboard bench for core_task_server against a
//              queue-based reference model of the dequeue/start/finish rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_core_task_server;
    localparam int DEPTH   = 4;
    localparam int TASK_W  = 32;
    localparam int TTYPE_W = 4;
    localparam int SLOT_W  = 6;
    localparam int CHILD_W = 3;
    localparam int NCYC    = 3000;
    localparam int M_IDLE = 0, M_DISP = 1, M_RUN = 2, M_REP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               cq_push_valid, cq_push_ready;
    logic [TASK_W-1:0]  cq_push_task;
    logic [SLOT_W-1:0]  cq_push_slot;
    logic               task_arvalid, task_rvalid;
    logic [TTYPE_W-1:0] task_araddr;
    logic [TASK_W-1:0]  task_rdata;
    logic [SLOT_W-1:0]  task_rslot;
    logic               start_task_valid, start_task_ready;
    logic [SLOT_W-1:0]  start_task_slot;
    logic               finish_task_valid, finish_task_ready;
    logic [SLOT_W-1:0]  finish_task_slot;
    logic [CHILD_W-1:0] finish_task_num_children;
    logic               finish_task_undo_log_write;
    logic               abort_req_valid;
    logic [SLOT_W-1:0]  abort_req_slot;
    logic               abort_running_task;
    logic [SLOT_W-1:0]  abort_running_slot;
    logic               done_valid, done_ready;
    logic [SLOT_W-1:0]  done_slot;
    logic [CHILD_W-1:0] done_num_children;
    logic               done_undo_write, done_aborted;
    logic [31:0]        stat_dispatched, stat_finished, stat_aborted;

    core_task_server #(
        .DEPTH(DEPTH), .CORE_ID(0), .TASK_W(TASK_W), .TTYPE_W(TTYPE_W),
        .SLOT_W(SLOT_W), .CHILD_W(CHILD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cq_push_valid(cq_push_valid), .cq_push_ready(cq_push_ready),
        .cq_push_task(cq_push_task), .cq_push_slot(cq_push_slot),
        .task_arvalid(task_arvalid), .task_araddr(task_araddr),
        .task_rvalid(task_rvalid), .task_rdata(task_rdata), .task_rslot(task_rslot),
        .start_task_valid(start_task_valid), .start_task_ready(start_task_ready),
        .start_task_slot(start_task_slot),
        .finish_task_valid(finish_task_valid), .finish_task_ready(finish_task_ready),
        .finish_task_slot(finish_task_slot),
        .finish_task_num_children(finish_task_num_children),
        .finish_task_undo_log_write(finish_task_undo_log_write),
        .abort_req_valid(abort_req_valid), .abort_req_slot(abort_req_slot),
        .abort_running_task(abort_running_task), .abort_running_slot(abort_running_slot),
        .done_valid(done_valid), .done_ready(done_ready), .done_slot(done_slot),
        .done_num_children(done_num_children), .done_undo_write(done_undo_write),
        .done_aborted(done_aborted),
        .stat_dispatched(stat_dispatched), .stat_finished(stat_finished),
        .stat_aborted(stat_aborted)
    );

    typedef struct { logic [TASK_W-1:0] t; logic [SLOT_W-1:0] s; bit v; } ent_t;
    typedef struct { int cyc; logic [SLOT_W-1:0] s; logic [TASK_W-1:0] t; } grant_exp_t;
    typedef struct { int cyc; logic [SLOT_W-1:0] s; } abort_exp_t;
    typedef struct { logic [SLOT_W-1:0] s; logic [CHILD_W-1:0] n; bit u; bit a; } done_exp_t;

    // Reference model: buffer as a plain queue, protocol as a small phase number.
    ent_t              m_q[$];
    int                m_st = M_IDLE;
    logic [SLOT_W-1:0] m_run_slot = '0;
    bit                m_aborted = 1'b0;
    int unsigned       m_ndisp = 0, m_nfin = 0, m_nabt = 0;

    grant_exp_t eg_q[$];
    abort_exp_t ea_q[$];
    done_exp_t  ed_q[$];

    int n_checks = 0, n_err = 0, cyc = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit full, head_ok, skip, grant, abort_run, abort_grant;
        logic [SLOT_W-1:0] hslot;
        if (rst) begin
            m_q.delete();
            m_st = M_IDLE; m_aborted = 1'b0; m_run_slot = '0;
            m_ndisp = 0; m_nfin = 0; m_nabt = 0;
            ed_q.delete();
            while (ea_q.size() > 0 && ea_q[ea_q.size()-1].cyc > cyc) void'(ea_q.pop_back());
            return;
        end
        full    = (m_q.size() == DEPTH);
        head_ok = (m_q.size() > 0) && m_q[0].v;
        skip    = (m_q.size() > 0) && !m_q[0].v;
        hslot   = (m_q.size() > 0) ? m_q[0].s : '0;
        grant   = task_arvalid && head_ok && (m_st == M_IDLE)
               && (m_q[0].t[TTYPE_W-1:0] == task_araddr);
        abort_run   = abort_req_valid && !m_aborted && (abort_req_slot == m_run_slot)
                   && (m_st == M_DISP || m_st == M_RUN);
        abort_grant = abort_req_valid && grant && (abort_req_slot == hslot);

        if (abort_req_valid)
            foreach (m_q[i]) if (m_q[i].s == abort_req_slot) m_q[i].v = 1'b0;

        if (grant) begin
            eg_q.push_back('{cyc, m_q[0].s, m_q[0].t});
            m_run_slot = m_q[0].s;
            m_aborted  = abort_grant;
            m_st       = M_DISP;
            m_ndisp++;
            void'(m_q.pop_front());
        end else begin
            if (abort_run) m_aborted = 1'b1;
            if (skip) void'(m_q.pop_front());
        end
        if (abort_run || abort_grant) begin
            ea_q.push_back('{cyc + 1, abort_req_slot});
            m_nabt++;
        end

        if (m_st == M_DISP && !grant && start_task_valid) m_st = M_RUN;
        else if (m_st == M_RUN && finish_task_valid) begin
            ed_q.push_back('{m_run_slot, finish_task_num_children,
                             finish_task_undo_log_write, m_aborted});
            m_st = M_REP;
        end else if (m_st == M_REP && done_ready) begin
            m_st = M_IDLE;
            m_nfin++;
        end

        if (cq_push_valid && !full) m_q.push_back('{cq_push_task, cq_push_slot, 1'b1});
    endtask

    // Driver: checks registered outputs against the model, then drives the next cycle.
    initial begin
        int phase;
        logic [TASK_W-1:0] tv;
        rst = 1'b1;
        {cq_push_valid, task_arvalid, start_task_valid, finish_task_valid,
         abort_req_valid, done_ready, finish_task_undo_log_write} = '0;
        cq_push_task = '0; cq_push_slot = '0; task_araddr = '0; start_task_slot = '0;
        finish_task_slot = '0; finish_task_num_children = '0; abort_req_slot = '0;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 3) begin
                started = 1'b1;
                check("push_ready", cq_push_ready, (m_q.size() < DEPTH));
                check("start_ready", start_task_ready, (m_st == M_DISP));
                check("finish_ready", finish_task_ready, (m_st == M_RUN));
                check("done_valid", done_valid, (m_st == M_REP));
`ifdef CORE_TASK_SERVER_STATS_EN
                check("stat_dispatched", stat_dispatched, m_ndisp);
                check("stat_finished", stat_finished, m_nfin);
                check("stat_aborted", stat_aborted, m_nabt);
`else
                check("stat_dispatched", stat_dispatched, 0);
                check("stat_finished", stat_finished, 0);
                check("stat_aborted", stat_aborted, 0);
`endif
            end
            rst = (cyc <= 2) || (cyc == 1500) || (cyc == 2600);
            phase = (cyc / 300) % 3;
            if (rst) begin
                {cq_push_valid, task_arvalid, start_task_valid, finish_task_valid,
                 abort_req_valid, done_ready} = '0;
            end else begin
                tv = $urandom();
                tv[TTYPE_W-1:0] = TTYPE_W'($urandom_range(0, 1));
                cq_push_valid    = $urandom_range(0, 99) < (phase == 1 ? 90 : 50);
                cq_push_task     = tv;
                cq_push_slot     = SLOT_W'($urandom_range(0, 7));
                task_arvalid     = $urandom_range(0, 99) < (phase == 1 ? 10 : 60);
                task_araddr      = TTYPE_W'($urandom_range(0, 1));
                start_task_valid = $urandom_range(0, 99) < 50;
                start_task_slot  = m_run_slot;
                finish_task_valid = $urandom_range(0, 99) < 40;
                finish_task_slot  = m_run_slot;
                finish_task_num_children   = CHILD_W'($urandom_range(0, 7));
                finish_task_undo_log_write = 1'($urandom_range(0, 1));
                abort_req_valid  = $urandom_range(0, 99) < 15;
                if (m_q.size() > 0 && $urandom_range(0, 99) < 30) abort_req_slot = m_q[0].s;
                else if ($urandom_range(0, 1) == 1)               abort_req_slot = m_run_slot;
                else abort_req_slot = SLOT_W'($urandom_range(0, 7));
                done_ready = $urandom_range(0, 99) < (phase == 2 ? 20 : 60);
            end
            #1 model_step();
        end
        #5;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Monitor: pops scoreboard entries whenever the DUT presents an output.
    initial begin
        grant_exp_t ge;
        abort_exp_t ae;
        done_exp_t  de;
        bit hs;
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                hs = task_arvalid && task_rvalid;
                if (eg_q.size() > 0 && eg_q[0].cyc == cyc) begin
                    ge = eg_q.pop_front();
                    check("grant_missing", hs, 1);
                    if (hs) begin
                        check("grant_slot", task_rslot, ge.s);
                        check("grant_data", task_rdata, ge.t);
                    end
                end else check("grant_unexpected", hs, 0);

                if (ea_q.size() > 0 && ea_q[0].cyc == cyc) begin
                    ae = ea_q.pop_front();
                    check("abort_pulse", abort_running_task, 1);
                    check("abort_slot", abort_running_slot, ae.s);
                end else check("abort_spurious", abort_running_task, 0);

                if (done_valid && done_ready) begin
                    if (ed_q.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL done_unexpected: got report slot %0d expected none (cycle %0d)",
                                 done_slot, cyc);
                    end else begin
                        de = ed_q.pop_front();
                        check("done_slot", done_slot, de.s);
                        check("done_children", done_num_children, de.n);
                        check("done_undo", done_undo_write, de.u);
                        check("done_aborted", done_aborted, de.a);
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire
